// File: rtl/attr_responder_pkg.sv
// Shared definitions for the attribute responder: status codes, FSM states
// and the bit layout of one table entry.
package attr_responder_pkg;

    localparam logic [1:0] ST_EXACT     = 2'b00;
    localparam logic [1:0] ST_DEFAULT   = 2'b01;
    localparam logic [1:0] ST_NOT_FOUND = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_SCAN = 2'b01,
        S_RESP = 2'b10
    } state_t;

    // Entry layout, MSB first: {valid, wild, key, port, value}
    function automatic int ent_port_lsb(input int val_w);
        return val_w;
    endfunction

    function automatic int ent_key_lsb(input int val_w, input int port_w);
        return val_w + port_w;
    endfunction

    function automatic int ent_wild_bit(input int val_w, input int port_w, input int key_w);
        return val_w + port_w + key_w;
    endfunction

    function automatic int ent_w(input int val_w, input int port_w, input int key_w);
        return val_w + port_w + key_w + 2;
    endfunction

endpackage

// File: rtl/attr_table.sv
// Attribute table storage: DEPTH entries, one write port and one
// combinational read port addressed by the scan index.
module attr_table
    import attr_responder_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int KEY_W  = 8,
    parameter int PORT_W = 4,
    parameter int VAL_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_idx,
    input  logic                     wr_en_entry,
    input  logic                     wr_wild,
    input  logic [KEY_W-1:0]         wr_key,
    input  logic [PORT_W-1:0]        wr_port,
    input  logic [VAL_W-1:0]         wr_value,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic                     rd_valid,
    output logic                     rd_wild,
    output logic [KEY_W-1:0]         rd_key,
    output logic [PORT_W-1:0]        rd_port,
    output logic [VAL_W-1:0]         rd_value
);

    localparam int DATA_BITS = ent_w(VAL_W, PORT_W, KEY_W) - 1;
    localparam int PORT_LSB  = ent_port_lsb(VAL_W);
    localparam int KEY_LSB   = ent_key_lsb(VAL_W, PORT_W);
    localparam int WILD_BIT  = ent_wild_bit(VAL_W, PORT_W, KEY_W);

    // Only the valid bits are reset; payload is don't-care while invalid.
    logic [DEPTH-1:0]     ent_vld;
    logic [DATA_BITS-1:0] ent_data [DEPTH];
    logic [DATA_BITS-1:0] rd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_vld <= '0;
        end else if (wr_en) begin
            ent_vld[wr_idx] <= wr_en_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            ent_data[wr_idx] <= {wr_wild, wr_key, wr_port, wr_value};
        end
    end

    assign rd_data  = ent_data[rd_idx];
    assign rd_valid = ent_vld[rd_idx];
    assign rd_wild  = rd_data[WILD_BIT];
    assign rd_key   = rd_data[KEY_LSB +: KEY_W];
    assign rd_port  = rd_data[PORT_LSB +: PORT_W];
    assign rd_value = rd_data[0 +: VAL_W];

endmodule

// File: rtl/attr_responder.sv
// Attribute-query responder: linear scan of the table resolving exact, then
// port-wildcard default, then not-found. Optional counters: ATTR_RESPONDER_STATS_EN.
module attr_responder
    import attr_responder_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int KEY_W  = 8,
    parameter int PORT_W = 4,
    parameter int VAL_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [$clog2(DEPTH)-1:0] wr_idx,
    input  logic                     wr_en_entry,
    input  logic                     wr_wild,
    input  logic [KEY_W-1:0]         wr_key,
    input  logic [PORT_W-1:0]        wr_port,
    input  logic [VAL_W-1:0]         wr_value,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [KEY_W-1:0]         req_key,
    input  logic [PORT_W-1:0]        req_port,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [VAL_W-1:0]         rsp_value,
    output logic [1:0]               rsp_status
`ifdef ATTR_RESPONDER_STATS_EN
    ,
    output logic [15:0]              stat_exact,
    output logic [15:0]              stat_default,
    output logic [15:0]              stat_miss
`endif
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    state_t              state, state_nxt;
    logic [IDX_W-1:0]    scan_idx, idx_nxt;
    logic [KEY_W-1:0]    q_key;
    logic [PORT_W-1:0]   q_port;
    logic                dflt_hit;
    logic [VAL_W-1:0]    dflt_val;
    logic                ld_query, rec_dflt, ld_rsp;
    logic [VAL_W-1:0]    rsp_value_nxt;
    logic [1:0]          rsp_status_nxt;
    logic                wr_fire;

    logic                rd_valid, rd_wild;
    logic [KEY_W-1:0]    rd_key;
    logic [PORT_W-1:0]   rd_port;
    logic [VAL_W-1:0]    rd_value;
    logic                exact_hit, dflt_match;

    assign wr_fire = wr_valid && wr_ready;

    attr_table #(
        .DEPTH  (DEPTH),
        .KEY_W  (KEY_W),
        .PORT_W (PORT_W),
        .VAL_W  (VAL_W)
    ) u_table (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_fire),
        .wr_idx      (wr_idx),
        .wr_en_entry (wr_en_entry),
        .wr_wild     (wr_wild),
        .wr_key      (wr_key),
        .wr_port     (wr_port),
        .wr_value    (wr_value),
        .rd_idx      (scan_idx),
        .rd_valid    (rd_valid),
        .rd_wild     (rd_wild),
        .rd_key      (rd_key),
        .rd_port     (rd_port),
        .rd_value    (rd_value)
    );

    // Wildcard entries only ever match as defaults, whatever port they carry.
    assign exact_hit  = rd_valid && !rd_wild && (rd_key == q_key) && (rd_port == q_port);
    assign dflt_match = rd_valid && rd_wild && (rd_key == q_key);

    always_comb begin
        state_nxt      = state;
        idx_nxt        = scan_idx;
        ld_query       = 1'b0;
        rec_dflt       = 1'b0;
        ld_rsp         = 1'b0;
        rsp_value_nxt  = rsp_value;
        rsp_status_nxt = rsp_status;
        wr_ready       = 1'b0;
        req_ready      = 1'b0;
        rsp_valid      = 1'b0;
        case (state)
            S_IDLE: begin
                wr_ready  = 1'b1;
                req_ready = !wr_valid;
                if (req_valid && !wr_valid) begin
                    ld_query  = 1'b1;
                    idx_nxt   = '0;
                    state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                if (exact_hit) begin
                    ld_rsp         = 1'b1;
                    rsp_value_nxt  = rd_value;
                    rsp_status_nxt = ST_EXACT;
                    state_nxt      = S_RESP;
                end else if (scan_idx == LAST_IDX) begin
                    ld_rsp    = 1'b1;
                    state_nxt = S_RESP;
                    if (dflt_hit) begin
                        rsp_value_nxt  = dflt_val;
                        rsp_status_nxt = ST_DEFAULT;
                    end else if (dflt_match) begin
                        rsp_value_nxt  = rd_value;
                        rsp_status_nxt = ST_DEFAULT;
                    end else begin
                        rsp_value_nxt  = '0;
                        rsp_status_nxt = ST_NOT_FOUND;
                    end
                end else begin
                    rec_dflt = dflt_match && !dflt_hit;
                    idx_nxt  = scan_idx + 1'b1;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            scan_idx   <= '0;
            dflt_hit   <= 1'b0;
            rsp_value  <= '0;
            rsp_status <= ST_EXACT;
        end else begin
            state    <= state_nxt;
            scan_idx <= idx_nxt;
            if (ld_query) begin
                dflt_hit <= 1'b0;
            end else if (rec_dflt) begin
                dflt_hit <= 1'b1;
            end
            if (ld_rsp) begin
                rsp_value  <= rsp_value_nxt;
                rsp_status <= rsp_status_nxt;
            end
        end
    end

    // Query operands and the recorded default value carry no reset.
    always_ff @(posedge clk) begin
        if (ld_query) begin
            q_key  <= req_key;
            q_port <= req_port;
        end
        if (rec_dflt) begin
            dflt_val <= rd_value;
        end
    end

`ifdef ATTR_RESPONDER_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_exact   <= '0;
            stat_default <= '0;
            stat_miss    <= '0;
        end else if (rsp_valid && rsp_ready) begin
            case (rsp_status)
                ST_EXACT:     stat_exact   <= sat_inc(stat_exact);
                ST_DEFAULT:   stat_default <= sat_inc(stat_default);
                ST_NOT_FOUND: stat_miss    <= sat_inc(stat_miss);
                default:      ;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_attr_responder.sv
// Self-checking bench for attr_responder: directed plan steps followed by
// randomized table writes and lookups checked against a reference model.
module tb_attr_responder;

    localparam int DEPTH  = 8;
    localparam int KEY_W  = 8;
    localparam int PORT_W = 4;
    localparam int VAL_W  = 16;
    localparam int IDX_W  = $clog2(DEPTH);

    localparam logic [7:0] K_LOAD = 8'h01;
    localparam logic [7:0] K_FOO  = 8'h02;
    localparam logic [3:0] P_A    = 4'd1;
    localparam logic [3:0] P_B    = 4'd2;
    localparam logic [3:0] P_CI   = 4'd3;

    logic              clk;
    logic              rst_n;
    logic              wr_valid, wr_ready;
    logic [IDX_W-1:0]  wr_idx;
    logic              wr_en_entry, wr_wild;
    logic [KEY_W-1:0]  wr_key;
    logic [PORT_W-1:0] wr_port;
    logic [VAL_W-1:0]  wr_value;
    logic              req_valid, req_ready;
    logic [KEY_W-1:0]  req_key;
    logic [PORT_W-1:0] req_port;
    logic              rsp_valid, rsp_ready;
    logic [VAL_W-1:0]  rsp_value;
    logic [1:0]        rsp_status;
`ifdef ATTR_RESPONDER_STATS_EN
    logic [15:0]       stat_exact, stat_default, stat_miss;
    int                m_stat [3];
`endif

    int n_tests;
    int n_fail;

    bit             m_vld  [DEPTH];
    bit             m_wild [DEPTH];
    logic [7:0]     m_key  [DEPTH];
    logic [3:0]     m_port [DEPTH];
    logic [15:0]    m_val  [DEPTH];

    attr_responder #(
        .DEPTH  (DEPTH),
        .KEY_W  (KEY_W),
        .PORT_W (PORT_W),
        .VAL_W  (VAL_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_idx      (wr_idx),
        .wr_en_entry (wr_en_entry),
        .wr_wild     (wr_wild),
        .wr_key      (wr_key),
        .wr_port     (wr_port),
        .wr_value    (wr_value),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_key     (req_key),
        .req_port    (req_port),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_value   (rsp_value),
        .rsp_status  (rsp_status)
`ifdef ATTR_RESPONDER_STATS_EN
        ,
        .stat_exact   (stat_exact),
        .stat_default (stat_default),
        .stat_miss    (stat_miss)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_vld[i] = 1'b0;
        end
`ifdef ATTR_RESPONDER_STATS_EN
        for (int i = 0; i < 3; i++) m_stat[i] = 0;
`endif
    endtask

    // Resolution: lowest-index exact entry, else lowest-index wildcard, else miss.
    task automatic model_lookup(input logic [7:0] key, input logic [3:0] port,
                                output logic [15:0] v, output logic [1:0] st, output int lat);
        bit found;
        found = 1'b0;
        v     = 16'h0000;
        st    = 2'b10;
        lat   = DEPTH + 1;
        for (int i = 0; i < DEPTH; i++) begin
            if (!found && m_vld[i] && !m_wild[i] && m_key[i] == key && m_port[i] == port) begin
                found = 1'b1;
                v     = m_val[i];
                st    = 2'b00;
                lat   = i + 2;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (!found && m_vld[i] && m_wild[i] && m_key[i] == key) begin
                found = 1'b1;
                v     = m_val[i];
                st    = 2'b01;
            end
        end
    endtask

`ifdef ATTR_RESPONDER_STATS_EN
    task automatic chk_stats();
        chk("stat_exact",   32'(stat_exact),   32'(m_stat[0]));
        chk("stat_default", 32'(stat_default), 32'(m_stat[1]));
        chk("stat_miss",    32'(stat_miss),    32'(m_stat[2]));
    endtask
`endif

    task automatic tb_write(input int idx, input bit en, input bit wild,
                            input logic [7:0] key, input logic [3:0] port, input logic [15:0] val);
        int g;
        wr_valid    = 1'b1;
        wr_idx      = IDX_W'(idx);
        wr_en_entry = en;
        wr_wild     = wild;
        wr_key      = key;
        wr_port     = port;
        wr_value    = val;
        #1;
        g = 0;
        while (!wr_ready && g < 50) begin
            step();
            g++;
        end
        chk("wr_ready", 32'(wr_ready), 32'd1);
        step();
        wr_valid    = 1'b0;
        m_vld[idx]  = en;
        m_wild[idx] = wild;
        m_key[idx]  = key;
        m_port[idx] = port;
        m_val[idx]  = val;
    endtask

    // Entered at edge+1 just after the accept edge (cycle 1 of the query).
    task automatic finish_query(input logic [7:0] key, input logic [3:0] port, input int hold,
                                output logic [15:0] obs_v, output logic [1:0] obs_st, output int obs_lat);
        logic [15:0] ev;
        logic [1:0]  est;
        int          elat;
        int          cyc;
        model_lookup(key, port, ev, est, elat);
        cyc = 1;
        while (!rsp_valid && cyc < 200) begin
            step();
            cyc++;
        end
        obs_v   = rsp_value;
        obs_st  = rsp_status;
        obs_lat = cyc;
        chk("rsp_latency", 32'(cyc), 32'(elat));
        chk("rsp_value", 32'(rsp_value), 32'(ev));
        chk("rsp_status", 32'(rsp_status), 32'(est));
        for (int h = 0; h < hold; h++) begin
            step();
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_value", 32'(rsp_value), 32'(ev));
            chk("hold_status", 32'(rsp_status), 32'(est));
            chk("hold_req_ready", 32'(req_ready), 32'd0);
            chk("hold_wr_ready", 32'(wr_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        #1;
        chk("rsp_drop", 32'(rsp_valid), 32'd0);
`ifdef ATTR_RESPONDER_STATS_EN
        m_stat[est]++;
        chk_stats();
`endif
    endtask

    task automatic query(input logic [7:0] key, input logic [3:0] port, input int hold,
                         output logic [15:0] obs_v, output logic [1:0] obs_st, output int obs_lat);
        int g;
        req_valid = 1'b1;
        req_key   = key;
        req_port  = port;
        #1;
        g = 0;
        while (!req_ready && g < 50) begin
            step();
            g++;
        end
        chk("req_ready", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        finish_query(key, port, hold, obs_v, obs_st, obs_lat);
    endtask

    initial begin
        logic [15:0] ov;
        logic [1:0]  ost;
        int          olat;
`ifdef ATTR_RESPONDER_STATS_EN
        logic [15:0] exact_before;
`endif
        n_tests     = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        wr_valid    = 1'b0;
        wr_idx      = '0;
        wr_en_entry = 1'b0;
        wr_wild     = 1'b0;
        wr_key      = '0;
        wr_port     = '0;
        wr_value    = '0;
        req_valid   = 1'b0;
        req_key     = '0;
        req_port    = '0;
        rsp_ready   = 1'b0;
        model_clear();

        // Reset state
        step();
        step();
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_value", 32'(rsp_value), 32'd0);
        chk("rst_rsp_status", 32'(rsp_status), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        rst_n = 1'b1;
        step();

        // Plan 1: reset in the middle of a scan
        tb_write(0, 1'b1, 1'b0, K_LOAD, P_A, 16'h011A);
        tb_write(2, 1'b1, 1'b1, K_LOAD, P_B, 16'h034D);
        req_valid = 1'b1;
        req_key   = K_LOAD;
        req_port  = P_CI;
        step();
        req_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("midscan_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midscan_wr_ready", 32'(wr_ready), 32'd1);
        chk("midscan_req_ready", 32'(req_ready), 32'd1);
        step();
        rst_n = 1'b1;
        model_clear();
        for (int i = 0; i < 12; i++) step();
        chk("no_stale_rsp", 32'(rsp_valid), 32'd0);
`ifdef ATTR_RESPONDER_STATS_EN
        chk_stats();
`endif
        query(K_LOAD, P_A, 0, ov, ost, olat);
        chk("t1_status", 32'(ost), 32'h2);
        chk("t1_value", 32'(ov), 32'h0);

        // Plan 2-4: exact, default, miss on a three-entry table
        tb_write(0, 1'b1, 1'b0, K_LOAD, P_A, 16'h011A);
        tb_write(1, 1'b1, 1'b0, K_LOAD, P_B, 16'h0233);
        tb_write(2, 1'b1, 1'b1, K_LOAD, 4'd0, 16'h034D);
        query(K_LOAD, P_B, 0, ov, ost, olat);
        chk("t2_status", 32'(ost), 32'h0);
        chk("t2_value", 32'(ov), 32'h0233);
        chk("t2_latency", 32'(olat), 32'd3);
        query(K_LOAD, P_CI, 0, ov, ost, olat);
        chk("t3_status", 32'(ost), 32'h1);
        chk("t3_value", 32'(ov), 32'h034D);
        chk("t3_latency", 32'(olat), 32'd9);
        query(K_FOO, P_A, 0, ov, ost, olat);
        chk("t4_status", 32'(ost), 32'h2);
        chk("t4_value", 32'(ov), 32'h0000);
        chk("t4_latency", 32'(olat), 32'd9);

        // Plan 5: response back-pressure
        query(K_LOAD, P_A, 5, ov, ost, olat);
        chk("t5_value", 32'(ov), 32'h011A);

        // Plan 6: write and request in the same idle cycle
`ifdef ATTR_RESPONDER_STATS_EN
        exact_before = stat_exact;
`endif
        wr_valid    = 1'b1;
        wr_idx      = IDX_W'(3);
        wr_en_entry = 1'b1;
        wr_wild     = 1'b0;
        wr_key      = K_FOO;
        wr_port     = P_A;
        wr_value    = 16'h0100;
        req_valid   = 1'b1;
        req_key     = K_FOO;
        req_port    = P_A;
        #1;
        chk("t6_req_blocked", 32'(req_ready), 32'd0);
        chk("t6_wr_ready", 32'(wr_ready), 32'd1);
        step();
        wr_valid  = 1'b0;
        m_vld[3]  = 1'b1;
        m_wild[3] = 1'b0;
        m_key[3]  = K_FOO;
        m_port[3] = P_A;
        m_val[3]  = 16'h0100;
        #1;
        chk("t6_req_ready", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        finish_query(K_FOO, P_A, 0, ov, ost, olat);
        chk("t6_status", 32'(ost), 32'h0);
        chk("t6_value", 32'(ov), 32'h0100);
`ifdef ATTR_RESPONDER_STATS_EN
        chk("t6_stat_delta", 32'(stat_exact - exact_before), 32'd1);
`endif

        // Wildcard whose port equals the request port still resolves as default
        tb_write(5, 1'b1, 1'b1, K_FOO, P_B, 16'h0500);
        query(K_FOO, P_B, 0, ov, ost, olat);
        chk("wild_status", 32'(ost), 32'h1);
        chk("wild_value", 32'(ov), 32'h0500);

        // Randomized writes and lookups against the model
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 9) < 6) begin
                tb_write(int'($urandom_range(0, DEPTH - 1)), ($urandom_range(0, 3) != 0),
                         1'($urandom_range(0, 1)), 8'($urandom_range(1, 3)),
                         4'($urandom_range(1, 3)), 16'($urandom));
            end else begin
                query(8'($urandom_range(1, 3)), 4'($urandom_range(1, 3)),
                      int'($urandom_range(0, 2)), ov, ost, olat);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
